// File: rtl/binary_counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the counter family.
//   - DEFAULT_WIDTH : default counter width (4 bits)
//   - bin2gray()    : binary to reflected-Gray conversion, usable by any
//                     counter up to 32 bits wide (callers cast to their width)
// No ports: package only.
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Each Gray bit is the XOR of a binary bit and its upper neighbour, so
  // adjacent values differ in exactly one bit. The argument is a fixed
  // 32-bit vector so a single function serves every counter width; narrower
  // callers zero-extend on the way in and truncate on the way out.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/binary_counter_if.sv
// ---------------------------------------------------------------------------
// binary_counter_if
//   Output bundle of binary_counter.
//   Parameters:
//     WIDTH      counter width in bits
//   Signals:
//     count      current counter value (registered)
//     tc         terminal count, high while count == MAX_VALUE
//     wrap       one-cycle pulse in the cycle after MAX_VALUE -> 0
//     count_gray Gray-coded count (only when BINARY_COUNTER_GRAY_EN is
//                defined)
//   Modports:
//     master     the counter, drives every signal
//     slave      any consumer, reads every signal
// ---------------------------------------------------------------------------
interface binary_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

`ifdef BINARY_COUNTER_GRAY_EN
  logic [WIDTH-1:0] count_gray;

  modport master (output count, output tc, output wrap, output count_gray);
  modport slave  (input  count, input  tc, input  wrap, input  count_gray);
`else
  modport master (output count, output tc, output wrap);
  modport slave  (input  count, input  tc, input  wrap);
`endif

endinterface

// File: rtl/binary_counter_bin2gray.sv
// ---------------------------------------------------------------------------
// counter_bin2gray
//   Purely combinational binary to Gray converter built on
//   counter_pkg::bin2gray.
//   Parameters:
//     WIDTH  vector width in bits (1..32)
//   Ports:
//     bin    in   WIDTH  binary value
//     gray   out  WIDTH  bin ^ (bin >> 1)
// ---------------------------------------------------------------------------
module counter_bin2gray
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Widen into the package function's 32-bit domain and back; the upper
  // result bits are zero because the input was zero-extended.
  assign gray = WIDTH'(bin2gray(32'(bin)));

endmodule

// File: rtl/binary_counter.sv
// ---------------------------------------------------------------------------
// binary_counter
//   Free-running synchronous binary up-counter. Counts 0..MAX_VALUE and then
//   wraps back to 0, one step per rising clock edge. No enable or load.
//
//   Parameters:
//     WIDTH      counter width in bits (>= 1)
//     MAX_VALUE  terminal count, 0 < MAX_VALUE <= 2**WIDTH-1
//   Ports:
//     clk        in      single clock, all state changes on the rising edge
//     rst        in      synchronous active-high reset
//     bus        master  count / tc / wrap (/ count_gray) outputs
//
//   Build option:
//     BINARY_COUNTER_GRAY_EN  adds a registered Gray-coded copy of count
//                             (bus.count_gray), aligned with count.
//
//   Outputs are X until rst has been sampled high once; there is no
//   power-on value.
// ---------------------------------------------------------------------------
module binary_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_VALUE = (1 << WIDTH) - 1
) (
  input  logic              clk,
  input  logic              rst,
  binary_counter_if.master  bus
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_next;
  logic             at_max;
  logic             wrap_q;

  // Terminal-count detect. Shared by the next-state mux, the wrap register
  // and the tc output so all three agree on when the counter is at the top.
  assign at_max = (count_q == MAX_COUNT);

  // Next-state mux. Wrapping on the compare rather than on natural overflow
  // lets MAX_VALUE be any value, not just 2**WIDTH-1.
  always_comb begin
    count_next = count_q + 1'b1;
    if (at_max) begin
      count_next = '0;
    end
  end

  // Count and wrap registers. wrap records that this edge took the counter
  // from MAX_VALUE to 0; a reset never counts as a wrap, even from
  // MAX_VALUE, because reset has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_next;
      wrap_q  <= at_max;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = at_max;
  assign bus.wrap  = wrap_q;

`ifdef BINARY_COUNTER_GRAY_EN
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] gray_q;

  // Convert the next count rather than the current one so the registered
  // Gray value lands in the same cycle as the binary value it encodes.
  counter_bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin  (count_next),
    .gray (gray_next)
  );

  // Gray register. Reset to 0, which is the Gray code of the reset count.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_next;
    end
  end

  assign bus.count_gray = gray_q;
`endif

endmodule

// File: tb/tb_binary_counter.sv
// ---------------------------------------------------------------------------
// tb_binary_counter
//   Drives two counters from a shared clk/rst: dutA with the full 4-bit
//   range and dutB with MAX_VALUE=9. The reference model keeps only the
//   number of edges since the last reset and derives every output from it
//   arithmetically. Build with BINARY_COUNTER_GRAY_EN to cover count_gray.
// ---------------------------------------------------------------------------
module tb_binary_counter;

  localparam int WIDTH = 4;
  localparam int MAXA  = 15;
  localparam int MAXB  = 9;

  logic clk;
  logic rst;

  int checks;
  int errors;

  // Edges since the most recent reset edge.
  int unsigned edgesSinceReset;

  binary_counter_if #(.WIDTH(WIDTH)) busA ();
  binary_counter_if #(.WIDTH(WIDTH)) busB ();

  binary_counter #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAXA)
  ) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  binary_counter #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAXB)
  ) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: after k edges out of reset the counter has advanced
  // k steps modulo MAX+1, and a wrap happened on this edge whenever k is a
  // positive multiple of MAX+1.
  function automatic int unsigned expCount(input int unsigned k, input int unsigned m);
    return k % (m + 1);
  endfunction

  function automatic int unsigned expWrap(input int unsigned k, input int unsigned m);
    return ((k != 0) && ((k % (m + 1)) == 0)) ? 1 : 0;
  endfunction

  function automatic int unsigned expTc(input int unsigned k, input int unsigned m);
    return (expCount(k, m) == m) ? 1 : 0;
  endfunction

  function automatic int unsigned expGray(input int unsigned k, input int unsigned m);
    int unsigned c;
    c = expCount(k, m);
    return c ^ (c >> 1);
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edgesSinceReset=%0d, t=%0t)",
               tag, observed, expected, edgesSinceReset, $time);
    end
  endtask

  // Compare every output of both counters against the model.
  task automatic checkAll();
    checkOutput("countA", 32'(busA.count), expCount(edgesSinceReset, MAXA));
    checkOutput("tcA",    32'(busA.tc),    expTc(edgesSinceReset, MAXA));
    checkOutput("wrapA",  32'(busA.wrap),  expWrap(edgesSinceReset, MAXA));
    checkOutput("countB", 32'(busB.count), expCount(edgesSinceReset, MAXB));
    checkOutput("tcB",    32'(busB.tc),    expTc(edgesSinceReset, MAXB));
    checkOutput("wrapB",  32'(busB.wrap),  expWrap(edgesSinceReset, MAXB));
`ifdef BINARY_COUNTER_GRAY_EN
    checkOutput("grayA", 32'(busA.count_gray), expGray(edgesSinceReset, MAXA));
    checkOutput("grayB", 32'(busB.count_gray), expGray(edgesSinceReset, MAXB));
    if (expCount(edgesSinceReset, MAXA) == 5)
      checkOutput("grayA5", 32'(busA.count_gray), 32'h7);
    if (expCount(edgesSinceReset, MAXA) == 15)
      checkOutput("grayA15", 32'(busA.count_gray), 32'h8);
`endif
  endtask

  // Present rst, take one rising edge, advance the model, then check the
  // outputs 1 time unit after the edge.
  task automatic applyStimulus(input logic rstValue);
    rst = rstValue;
    @(posedge clk);
    if (rstValue) edgesSinceReset = 0;
    else          edgesSinceReset++;
    #1;
    checkAll();
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    edgesSinceReset = 0;
    rst             = 1'b1;

    $display("[TB] reset for two edges");
    repeat (2) applyStimulus(1'b1);

    $display("[TB] one full cycle of dutA (wraps dutB along the way)");
    repeat (16) applyStimulus(1'b0);

    $display("[TB] reset at count 5, then resume");
    applyStimulus(1'b1);
    repeat (5) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (4) applyStimulus(1'b0);

    $display("[TB] reset while dutA sits at its terminal count");
    applyStimulus(1'b1);
    repeat (15) applyStimulus(1'b0);
    applyStimulus(1'b1);

    $display("[TB] hold reset for 10 edges");
    repeat (10) applyStimulus(1'b1);

    $display("[TB] long free run");
    repeat (48) applyStimulus(1'b0);

    $display("[TB] randomized reset pattern");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
